// File: rtl/progmem_pkg.sv
// Shared types and constants for the program-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package progmem_pkg;

    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int DEPTH      = 16384;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One requester's command bundle, as presented on its Avalon-MM port.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic [BE_WIDTH-1:0]   byteenable;
        logic                  read;
        logic                  write;
        logic [DATA_WIDTH-1:0] writedata;
    } req_t;

endpackage

// File: rtl/progmem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a registered last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the clock edge.
// Backpressure: the loser simply gets no grant and must hold its request.
//
// Ports: clk/reset (async active-high), i_req[1:0] requests, i_advance
// (a granted transfer completes this cycle), o_grant[1:0] one-hot grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // 1 = requester 1 won last; reset value makes requester 0 win first.
    logic r_last_m1;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_last_m1 ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_m1 <= 1'b1;
        end else if (i_advance && (o_grant != 2'b00)) begin
            r_last_m1 <= o_grant[1];
        end
    end

endmodule

// File: rtl/progmem_arbiter.sv
// Round-robin arbiter for two Avalon-MM requesters onto one single-port RAM,
// with a zero-fill sequencer. Latency: grant same cycle, readdatavalid +1 cycle.
// Backpressure: waitrequest=1 for the losing requester, during clear and in reset.
//
// Ports: clk, reset (async active-high); m0_*/m1_* Avalon-MM slave ports
// (address, byteenable, read, write, writedata, waitrequest, readdata,
// readdatavalid); clear_start/clear_busy/clear_done sweep control; ram_* RAM
// master side (address, byteenable, chipselect, write, writedata, clken, readdata).
module progmem_arbiter #(
    parameter int ADDR_WIDTH = progmem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = progmem_pkg::DATA_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int DEPTH      = progmem_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdatavalid,

    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [BE_WIDTH-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_WIDTH-1:0] ram_readdata
);

    import progmem_pkg::*;

    // One spare bit so DEPTH == 2**ADDR_WIDTH still reaches its last index without wrapping.
    localparam int              CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_rd_owner;

    logic               w_idle;
    logic [1:0]         w_req;
    logic [1:0]         w_grant;
    req_t               w_m0;
    req_t               w_m1;
    req_t               w_win;

    assign w_m0 = '{address: m0_address, byteenable: m0_byteenable, read: m0_read,
                    write: m0_write, writedata: m0_writedata};
    assign w_m1 = '{address: m1_address, byteenable: m1_byteenable, read: m1_read,
                    write: m1_write, writedata: m1_writedata};

    assign w_idle = (r_state == IDLE);

    // Requests are masked outside IDLE, so any grant implies an accepted transfer.
    assign w_req = {w_m1.read | w_m1.write, w_m0.read | w_m0.write} & {2{w_idle & ~reset}};

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_req),
        .i_advance (w_idle),
        .o_grant   (w_grant)
    );

    assign w_win = w_grant[1] ? w_m1 : w_m0;

    assign m0_waitrequest = reset | ~w_grant[0];
    assign m1_waitrequest = reset | ~w_grant[1];

    // Single RAM read port is shared; only the owner's valid qualifies it.
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = r_rd_owner[0];
    assign m1_readdatavalid = r_rd_owner[1];

    assign clear_busy = (r_state == CLEAR);
    assign clear_done = (r_state == DONE);
    assign ram_clken  = ~reset;

    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = w_win.address;
        ram_byteenable = w_win.byteenable;
        ram_writedata  = w_win.writedata;
        if (reset) begin
            ram_chipselect = 1'b0;
        end else if (r_state == CLEAR) begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_address    = r_cnt[ADDR_WIDTH-1:0];
            ram_byteenable = '1;
            ram_writedata  = '0;
        end else if (w_grant != 2'b00) begin
            ram_chipselect = 1'b1;
            ram_write      = w_win.write;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clear_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd_owner <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Write has priority when both strobes are raised, so no read is returned.
            r_rd_owner <= {w_grant[1] & w_m1.read & ~w_m1.write,
                           w_grant[0] & w_m0.read & ~w_m0.write};
        end
    end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Directed bench for progmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_progmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [13:0] m0_address = '0;
    logic [3:0]  m0_byteenable = '0;
    logic        m0_read = 1'b0;
    logic        m0_write = 1'b0;
    logic [31:0] m0_writedata = '0;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;

    logic [13:0] m1_address = '0;
    logic [3:0]  m1_byteenable = '0;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m1_writedata = '0;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;

    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic        clear_done;

    logic [13:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;

    logic [31:0] mem [0:16383];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    progmem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .clear_start      (clear_start),
        .clear_busy       (clear_busy),
        .clear_done       (clear_done),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_readdata)
    );

    // Behavioural single-port RAM: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n_wait0;
        int n_wait1;
        int cnt;
        logic [13:0] rd_addrs [5];

        rd_addrs = '{14'h0010, 14'h0001, 14'h0100, 14'h3FFF, 14'h02A5};
        mem[1]      = 32'h0101_0101;
        mem[2]      = 32'h0202_0202;
        mem[16]     = 32'hDEAD_BEEF;
        mem[256]    = 32'h1122_3344;

        // Reset state, with a request pending to show waitrequest is forced.
        m0_read = 1'b1;
        tick;
        tick;
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        chk("rst_m1_rdv", m1_readdatavalid, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_wr", ram_write, 0);
        chk("rst_clken", ram_clken, 0);
        m0_read = 1'b0;
        reset   = 1'b0;
        tick;
        chk("clken_run", ram_clken, 1);

        // Both read from reset: m0 first, m1 next cycle.
        m0_address = 14'h0001; m0_read = 1'b1;
        m1_address = 14'h0002; m1_read = 1'b1;
        #1;
        chk("both_c0_m0_wait", m0_waitrequest, 0);
        chk("both_c0_m1_wait", m1_waitrequest, 1);
        chk("both_c0_addr", ram_address, 14'h0001);
        tick;
        m0_read = 1'b0;
        #1;
        chk("both_c1_m0_rdv", m0_readdatavalid, 1);
        chk("both_c1_m0_data", m0_readdata, 32'h0101_0101);
        chk("both_c1_m1_rdv", m1_readdatavalid, 0);
        chk("both_c1_m1_wait", m1_waitrequest, 0);
        chk("both_c1_addr", ram_address, 14'h0002);
        tick;
        m1_read = 1'b0;
        chk("both_c2_m1_rdv", m1_readdatavalid, 1);
        chk("both_c2_m1_data", m1_readdata, 32'h0202_0202);
        chk("both_c2_m0_rdv", m0_readdatavalid, 0);

        // m0 reads 0x0010 alone.
        m0_address = 14'h0010; m0_read = 1'b1;
        #1;
        chk("solo_m0_wait", m0_waitrequest, 0);
        chk("solo_cs", ram_chipselect, 1);
        chk("solo_wr", ram_write, 0);
        tick;
        m0_read = 1'b0;
        chk("solo_m0_rdv", m0_readdatavalid, 1);
        chk("solo_m0_data", m0_readdata, 32'hDEAD_BEEF);
        chk("solo_m1_rdv", m1_readdatavalid, 0);
        tick;
        chk("solo_m0_rdv_drop", m0_readdatavalid, 0);

        // m1 partial write then readback.
        m1_address = 14'h0100; m1_write = 1'b1; m1_byteenable = 4'b0011;
        m1_writedata = 32'hAABB_CCDD;
        #1;
        chk("be_wr_wait", m1_waitrequest, 0);
        chk("be_wr_ramwr", ram_write, 1);
        chk("be_wr_be", ram_byteenable, 4'b0011);
        chk("be_wr_wd", ram_writedata, 32'hAABB_CCDD);
        tick;
        m1_write = 1'b0; m1_read = 1'b1;
        #1;
        chk("be_rd_wait", m1_waitrequest, 0);
        chk("be_rd_ramwr", ram_write, 0);
        tick;
        m1_read = 1'b0;
        chk("be_rd_rdv", m1_readdatavalid, 1);
        chk("be_rd_data", m1_readdata, 32'h1122_CCDD);

        // Six cycles of contention: strict alternation starting with m0.
        m0_address = 14'h0200; m0_writedata = 32'h0000_00A0; m0_byteenable = 4'hF; m0_write = 1'b1;
        m1_address = 14'h0201; m1_writedata = 32'h0000_00B1; m1_byteenable = 4'hF; m1_write = 1'b1;
        n_wait0 = 0;
        n_wait1 = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("alt_m0_wait_%0d", i), m0_waitrequest, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("alt_m1_wait_%0d", i), m1_waitrequest, (i % 2 == 1) ? 0 : 1);
            if (m0_waitrequest === 1'b0) n_wait0++;
            if (m1_waitrequest === 1'b0) n_wait1++;
            tick;
        end
        m0_write = 1'b0;
        m1_write = 1'b0;
        chk("alt_m0_grants", n_wait0, 3);
        chk("alt_m1_grants", n_wait1, 3);

        // Clear: a read granted in the clear_start cycle still completes.
        m0_address = 14'h0200; m0_read = 1'b1; clear_start = 1'b1;
        #1;
        chk("clr_start_m0_wait", m0_waitrequest, 0);
        tick;
        clear_start = 1'b0;
        m0_address = 14'h0010;
        #1;
        chk("clr_busy_first", clear_busy, 1);
        chk("clr_m0_rdv", m0_readdatavalid, 1);
        chk("clr_m0_data", m0_readdata, 32'h0000_00A0);
        chk("clr_m0_wait", m0_waitrequest, 1);
        chk("clr_addr0", ram_address, 14'h0000);
        chk("clr_wr", ram_write, 1);
        chk("clr_be", ram_byteenable, 4'hF);
        chk("clr_wd", ram_writedata, 32'h0);
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 20000) begin
            cnt++;
            clear_start = (cnt == 100);
            tick;
        end
        clear_start = 1'b0;
        chk("clr_busy_cycles", cnt, 16384);
        chk("clr_done", clear_done, 1);
        chk("clr_done_wait", m0_waitrequest, 1);
        chk("clr_done_cs", ram_chipselect, 0);
        tick;
        chk("clr_done_pulse", clear_done, 0);
        for (int k = 0; k < 5; k++) begin
            m0_address = rd_addrs[k];
            #1;
            chk($sformatf("zrd_wait_%0d", k), m0_waitrequest, 0);
            tick;
            chk($sformatf("zrd_rdv_%0d", k), m0_readdatavalid, 1);
            chk($sformatf("zrd_data_%0d", k), m0_readdata, 32'h0);
        end
        m0_read = 1'b0;
        tick;

        // Reset in the middle of a sweep.
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        m0_read = 1'b1;
        cnt = 0;
        while (ram_address !== 14'h0800 && cnt < 5000) begin
            cnt++;
            tick;
        end
        chk("mid_addr_reached", ram_address, 14'h0800);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", clear_busy, 0);
        chk("mid_rst_done", clear_done, 0);
        chk("mid_rst_wait", m0_waitrequest, 1);
        chk("mid_rst_cs", ram_chipselect, 0);
        chk("mid_rst_wr", ram_write, 0);
        chk("mid_rst_clken", ram_clken, 0);
        m0_read = 1'b0;
        tick;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("mid_no_done_%0d", k), clear_done, 0);
        end
        m0_address = 14'h0010; m0_writedata = 32'h0000_0055; m0_byteenable = 4'hF; m0_write = 1'b1;
        #1;
        chk("post_wr_wait", m0_waitrequest, 0);
        tick;
        m0_write = 1'b0; m0_read = 1'b1;
        #1;
        chk("post_rd_wait", m0_waitrequest, 0);
        tick;
        m0_read = 1'b0;
        chk("post_rd_rdv", m0_readdatavalid, 1);
        chk("post_rd_data", m0_readdata, 32'h0000_0055);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
